muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- HI/LO multiply-divide responder for the 5-stage MIPS pipeline.
- The EX stage issues one operation per `start` pulse with operands regA/regB. The unit answers with `busy` for a fixed latency, then commits HI/LO.
- The pipeline's hazard logic reads `busy` and `start` to stall mfhi/mflo and further md ops. HI/LO values pass down the pipe to writeback.

Parameters:
MUL_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  issue strobe from EX stage, sampled on rising clk
op  input  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo, 6/7 reserved
a  input  32  rs operand (forwarded regA)
b  input  32  rt operand (forwarded regB)
busy  output  1  operation in flight
done  output  1  one-cycle pulse in the cycle HI/LO take new md result
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, pending regs=0. Reset mid-operation discards the pending result; HI/LO stay 0.
- States: IDLE, RUN.
- IDLE, start=1, op in {0..3}:
  - Operands are sampled at this edge.
  - The full result is computed into pending_hi/pending_lo.
  - counter loads MUL_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - busy=1 from the next cycle; state goes to RUN.
- RUN: counter decrements each cycle. On the edge where counter==1:
  - hi<=pending_hi, lo<=pending_lo.
  - done=1 for the following cycle, busy=0, state goes to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
- mthi/mtlo (op 4/5) in IDLE: hi<=a or lo<=a at the start edge. busy stays 0, done stays 0.
- start while busy=1: ignored entirely, no state or HI/LO change. The pipeline is required to stall instead.
- start in the same cycle busy falls (the IDLE cycle after commit) is accepted normally. Back-to-back operations lose no cycle.
- Reserved op 6/7: ignored.
- HI/LO hold old values throughout RUN. mfhi/mflo while busy must stall.
- mult: signed 32x32->64; hi=upper word, lo=lower word. multu: same, unsigned.
- div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend. Overflow 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (div/divu, b=0): lo=0xFFFFFFFF, hi=a. Normal latency applies.
- done and busy are registered outputs, not combinational from start.

Test Plan:
1. reset low mid-RUN of a div (a=100, b=7, cycle 4) -> immediately busy=0, hi=0, lo=0. After release, no done pulse appears and HI/LO stay 0.
2. mult a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
3. div a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 -> lo=3, hi=1.
4. div a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
5. mult 2*3 issued, then start with mthi a=0xDEAD during busy -> mthi ignored; commit gives hi=0, lo=6. Next, start mtlo a=0xBEEF in the first IDLE cycle -> lo=0xBEEF next edge, busy stays 0.
6. multu 0xFFFFFFFF*0xFFFFFFFF, then divu 9/4 issued the cycle after done -> first commit hi=0xFFFFFFFE, lo=0x00000001. divu commits 10 cycles later with lo=2, hi=1.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide responder for a 5-stage MIPS pipeline.
// An md op computes its full 64-bit result at the issue edge and parks it in
// pending registers. busy stays high for a fixed latency, then HI/LO commit
// and done pulses for one cycle. mthi/mtlo write HI/LO directly when idle.
module muldiv_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d;
  logic [31:0]       pend_lo_q, pend_lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Arithmetic datapath signals
  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Result computation for the op presented at the issue edge. Signed divide
  // runs on magnitudes and restores signs afterwards: quotient negative when
  // operand signs differ, remainder follows the dividend. The 0x80000000/-1
  // overflow falls out naturally (magnitude 0x80000000 negates to itself).
  always_comb begin
    mul_s      = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    mul_u      = {32'd0, a} * {32'd0, b};
    div_signed = (op == OP_DIV);
    a_neg      = div_signed & a[31];
    b_neg      = div_signed & b[31];
    dvd_mag    = a_neg ? (32'd0 - a) : a;
    dvs_mag    = b_neg ? (32'd0 - b) : b;
    // Keep the divider operand nonzero; the b==0 case is overridden below.
    dvs_safe   = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
    q_mag      = dvd_mag / dvs_safe;
    r_mag      = dvd_mag % dvs_safe;
    q_fix      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r_fix      = a_neg ? (32'd0 - r_mag) : r_mag;
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    case (op)
      OP_MULT: begin
        res_hi = mul_s[63:32];
        res_lo = mul_s[31:0];
      end
      OP_MULTU: begin
        res_hi = mul_u[63:32];
        res_lo = mul_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = r_fix;
          res_lo = q_fix;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // Next-state logic: issue in IDLE, count down in RUN, commit on the last count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              cnt_d     = (op[1]) ? DIV_LOAD : MUL_LOAD;
              busy_d    = 1'b1;
              state_d   = S_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: begin
              // Reserved encodings are dropped.
            end
          endcase
        end
      end
      S_RUN: begin
        // start is ignored here; the pipeline must stall md ops while busy.
        if (cnt_q <= CNT_ONE) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; an async reset discards any pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
